// File: rtl/ram_cipher_bridge_pkg.sv
// ram_cipher_bridge_pkg: shared definitions for the receive-RAM -> cipher ->
// send-RAM bridge.
//   state_e          FSM state encoding (IDLE, LOAD, CIPHER, STORE, FINISH)
//   NIBBLES_PER_BLK  nibbles packed into one cipher block
//   BLKS_PER_BUF     cipher blocks per 512-byte buffer
package ram_cipher_bridge_pkg;

  localparam int unsigned NIBBLES_PER_BLK = 16;
  localparam int unsigned BLKS_PER_BUF    = 64;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_CIPHER = 3'd2,
    ST_STORE  = 3'd3,
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/nibble_shift64.sv
// nibble_shift64: block register loaded one nibble per cycle MSB-first, plus
// the nibble selector used when storing a result word.
//   iclk, irst   clock, synchronous active-high reset (clears block register)
//   ishift_en    shift inibble into the low end of the block register
//   inibble      nibble from receive RAM
//   oblk         block register contents
//   isel_word    word to pick a nibble from
//   isel_idx     nibble index, 0 = most significant nibble
//   osel_nibble  selected nibble
module nibble_shift64 #(
  parameter int unsigned BLK_W = 64
) (
  input  logic             iclk,
  input  logic             irst,
  input  logic             ishift_en,
  input  logic [3:0]       inibble,
  output logic [BLK_W-1:0] oblk,
  input  logic [BLK_W-1:0] isel_word,
  input  logic [3:0]       isel_idx,
  output logic [3:0]       osel_nibble
);

  logic [BLK_W-1:0] blk_q, blk_d;
  logic [BLK_W-1:0] sel_shifted;

  always_comb begin
    blk_d = blk_q;
    if (ishift_en) blk_d = {blk_q[BLK_W-5:0], inibble};
  end

  always_ff @(posedge iclk) begin
    if (irst) blk_q <= '0;
    else      blk_q <= blk_d;
  end

  assign oblk = blk_q;

  // Shift the wanted nibble up to the top so index 0 is always the MSB nibble.
  always_comb begin
    sel_shifted = isel_word << (4 * isel_idx);
    osel_nibble = sel_shifted[BLK_W-1 -: 4];
  end

endmodule

// File: rtl/ram_cipher_bridge.sv
// ram_cipher_bridge: reads a 1024-nibble receive RAM block by block, packs 16
// nibbles MSB-first into a cipher block, hands it to an external cipher core,
// and writes the result nibbles to the send RAM at the same addresses.
//   iclk, irst             clock, synchronous active-high reset
//   istart                 start processing (honoured only when idle)
//   ord_addr / irdata      receive-RAM read port (data one cycle after address)
//   owr_addr/owdata/owrite_en  send-RAM write port
//   oblock/ocipher_start   block to cipher and one-cycle start pulse
//   iblock/icipher_done    cipher result and completion strobe
//   obusy / odone          processing flag, one-cycle completion pulse
//   ibypass                (only with RCB_BYPASS_EN) copy block instead of ciphering
module ram_cipher_bridge
  import ram_cipher_bridge_pkg::*;
#(
  parameter int unsigned ADDR_W = 10,
  parameter int unsigned BLK_W  = 64
) (
  input  logic              iclk,
  input  logic              irst,
  input  logic              istart,
`ifdef RCB_BYPASS_EN
  input  logic              ibypass,
`endif
  output logic [ADDR_W-1:0] ord_addr,
  input  logic [3:0]        irdata,
  output logic [ADDR_W-1:0] owr_addr,
  output logic [3:0]        owdata,
  output logic              owrite_en,
  output logic [BLK_W-1:0]  oblock,
  output logic              ocipher_start,
  input  logic [BLK_W-1:0]  iblock,
  input  logic              icipher_done,
  output logic              obusy,
  output logic              odone
);

  localparam int unsigned BCNT_W = ADDR_W - 4;
  localparam logic [BCNT_W-1:0] LAST_BLK = BCNT_W'(BLKS_PER_BUF - 1);

  state_e             state_q, state_d;
  logic [BCNT_W-1:0]  blk_q, blk_d;
  logic [4:0]         k_q, k_d;
  logic [BLK_W-1:0]   res_q, res_d;
  logic [ADDR_W-1:0]  ord_addr_q, ord_addr_d;
  logic [ADDR_W-1:0]  owr_addr_q, owr_addr_d;
  logic [3:0]         owdata_q, owdata_d;
  logic               owrite_en_q, owrite_en_d;
  logic               cstart_q, cstart_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               bypass_q, bypass_d;
  logic               byp_in;
  logic               shift_en;
  logic [BLK_W-1:0]   blk_word;
  logic [3:0]         sel_nibble;
  logic [3:0]         k_inc;

`ifdef RCB_BYPASS_EN
  assign byp_in = ibypass;
`else
  assign byp_in = 1'b0;
`endif

  nibble_shift64 #(.BLK_W(BLK_W)) u_shift (
    .iclk        (iclk),
    .irst        (irst),
    .ishift_en   (shift_en),
    .inibble     (irdata),
    .oblk        (blk_word),
    .isel_word   (res_d),
    .isel_idx    (k_d[3:0]),
    .osel_nibble (sel_nibble)
  );

  assign k_inc = k_q[3:0] + 4'd1;

  always_comb begin
    state_d     = state_q;
    blk_d       = blk_q;
    k_d         = k_q;
    res_d       = res_q;
    ord_addr_d  = ord_addr_q;
    owr_addr_d  = owr_addr_q;
    owrite_en_d = 1'b0;
    cstart_d    = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;
    bypass_d    = bypass_q;
    shift_en    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (istart) begin
          state_d    = ST_LOAD;
          blk_d      = '0;
          k_d        = '0;
          ord_addr_d = '0;
          busy_d     = 1'b1;
          bypass_d   = byp_in;
        end
      end
      ST_LOAD: begin
        // Read data lags the address by one cycle, so capture runs k=1..16.
        shift_en = (k_q != 5'd0);
        if (k_q == 5'd16) begin
          state_d  = ST_CIPHER;
          k_d      = '0;
          cstart_d = ~bypass_q;
        end else begin
          k_d = k_q + 5'd1;
          if (k_q < 5'd15) ord_addr_d = {blk_q, k_inc};
        end
      end
      ST_CIPHER: begin
        // k_q marks the first CIPHER cycle; bypass copies on the second one,
        // behaving like a cipher that answers one cycle after start.
        k_d = 5'd1;
        if (bypass_q ? (k_q != 5'd0) : icipher_done) begin
          res_d       = bypass_q ? blk_word : iblock;
          state_d     = ST_STORE;
          k_d         = '0;
          owrite_en_d = 1'b1;
          owr_addr_d  = {blk_q, 4'd0};
        end
      end
      ST_STORE: begin
        if (k_q[3:0] == 4'd15) begin
          if (blk_q == LAST_BLK) begin
            state_d = ST_FINISH;
            done_d  = 1'b1;
          end else begin
            state_d    = ST_LOAD;
            blk_d      = blk_q + BCNT_W'(1);
            k_d        = '0;
            ord_addr_d = {blk_d, 4'd0};
            bypass_d   = byp_in;
          end
        end else begin
          k_d         = k_q + 5'd1;
          owrite_en_d = 1'b1;
          owr_addr_d  = {blk_q, k_inc};
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Write data is registered alongside the address, picked from next-state
  // result word and index so it lines up with owr_addr.
  always_comb begin
    owdata_d = owdata_q;
    if (owrite_en_d) owdata_d = sel_nibble;
  end

  always_ff @(posedge iclk) begin
    if (irst) begin
      state_q     <= ST_IDLE;
      blk_q       <= '0;
      k_q         <= '0;
      res_q       <= '0;
      ord_addr_q  <= '0;
      owr_addr_q  <= '0;
      owdata_q    <= '0;
      owrite_en_q <= 1'b0;
      cstart_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      bypass_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      blk_q       <= blk_d;
      k_q         <= k_d;
      res_q       <= res_d;
      ord_addr_q  <= ord_addr_d;
      owr_addr_q  <= owr_addr_d;
      owdata_q    <= owdata_d;
      owrite_en_q <= owrite_en_d;
      cstart_q    <= cstart_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      bypass_q    <= bypass_d;
    end
  end

  assign ord_addr      = ord_addr_q;
  assign owr_addr      = owr_addr_q;
  assign owdata        = owdata_q;
  assign owrite_en     = owrite_en_q;
  assign oblock        = blk_word;
  assign ocipher_start = cstart_q;
  assign obusy         = busy_q;
  assign odone         = done_q;

endmodule

// File: tb/tb_ram_cipher_bridge.sv
// tb_ram_cipher_bridge: self-checking bench for ram_cipher_bridge with
// receive/send RAM models, a configurable cipher core model and a reference
// computation of the send-RAM image. Build with RCB_BYPASS_EN to also cover
// the bypass path.
module tb_ram_cipher_bridge;

  localparam int unsigned AW = 10;
  localparam int unsigned BW = 64;
  localparam int unsigned NW = 1024;

  logic          iclk = 1'b0;
  logic          irst, istart;
  logic [AW-1:0] ord_addr, owr_addr;
  logic [3:0]    irdata, owdata;
  logic          owrite_en, ocipher_start, icipher_done, obusy, odone;
  logic [BW-1:0] oblock, iblock;
`ifdef RCB_BYPASS_EN
  logic          ibypass;
`endif

  always #5 iclk = ~iclk;

  ram_cipher_bridge #(.ADDR_W(AW), .BLK_W(BW)) dut (
    .iclk          (iclk),
    .irst          (irst),
    .istart        (istart),
`ifdef RCB_BYPASS_EN
    .ibypass       (ibypass),
`endif
    .ord_addr      (ord_addr),
    .irdata        (irdata),
    .owr_addr      (owr_addr),
    .owdata        (owdata),
    .owrite_en     (owrite_en),
    .oblock        (oblock),
    .ocipher_start (ocipher_start),
    .iblock        (iblock),
    .icipher_done  (icipher_done),
    .obusy         (obusy),
    .odone         (odone)
  );

  int checks   = 0;
  int failures = 0;

  logic [3:0] rx_ram [NW];
  logic [3:0] tx_ram [NW];

  // environment state
  int          cmode, cwait;
  logic [63:0] ckey;
  bit          clr, spur_armed;
  int          wr_cnt, addr_err, start_cnt, done_cnt, stab_err, rem;
  logic [63:0] cap, first_blk;
  bit          first_seen;

  function automatic logic [63:0] cfun(input logic [63:0] b);
    case (cmode)
      0:       return b;
      1:       return ~b;
      default: return b ^ ckey;
    endcase
  endfunction

  // RAMs, cipher core and event counters
  always @(posedge iclk) begin
    irdata       <= rx_ram[ord_addr];
    icipher_done <= 1'b0;
    if (clr) begin
      wr_cnt <= 0; addr_err <= 0; start_cnt <= 0; done_cnt <= 0;
      stab_err <= 0; rem <= 0; first_seen <= 1'b0;
    end else begin
      if (owrite_en) begin
        tx_ram[owr_addr] <= owdata;
        if (owr_addr != AW'(wr_cnt)) addr_err <= addr_err + 1;
        wr_cnt <= wr_cnt + 1;
        if (spur_armed && owr_addr[3:0] == 4'd3) icipher_done <= 1'b1;
      end
      if (odone) done_cnt <= done_cnt + 1;
      if (ocipher_start) begin
        start_cnt <= start_cnt + 1;
        cap       <= oblock;
        if (!first_seen) begin first_blk <= oblock; first_seen <= 1'b1; end
        if (cwait <= 1) begin
          icipher_done <= 1'b1; iblock <= cfun(oblock); rem <= 0;
        end else rem <= cwait - 1;
      end else if (rem != 0) begin
        if (oblock != cap) stab_err <= stab_err + 1;
        rem <= rem - 1;
        if (rem == 1) begin icipher_done <= 1'b1; iblock <= cfun(cap); end
      end
    end
  end

  task automatic tick();
    @(posedge iclk);
    #1;
  endtask

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic fill_rx(input int pat);
    for (int n = 0; n < NW; n++) begin
      case (pat)
        0:       rx_ram[n] = 4'(n);
        1:       rx_ram[n] = ~4'(n);
        default: rx_ram[n] = 4'($urandom);
      endcase
    end
  endtask

  task automatic clear_env();
    clr = 1'b1;
    tick();
    clr = 1'b0;
  endtask

  // Reference image: pack 16 nibbles MSB-first, apply the cipher, unpack.
  task automatic check_image(input string nm);
    int bad = 0;
    logic [63:0] w, r;
    for (int b = 0; b < 64; b++) begin
      w = '0;
      for (int i = 0; i < 16; i++) w = (w << 4) | 64'(rx_ram[b*16+i]);
      r = cfun(w);
      for (int i = 0; i < 16; i++)
        if (tx_ram[b*16+i] !== r[63-4*i -: 4]) bad++;
    end
    check({nm, "_image"}, 64'(bad), 64'd0);
  endtask

  // Runs one buffer; cycle count includes the istart cycle.
  task automatic run_buffer(input string nm, input int exp_cyc, input bit spur, input int exp_starts);
    int cyc;
    bit injected = 1'b0;
    clear_env();
    spur_armed = spur;
    istart = 1'b1;
    tick();
    istart = 1'b0;
    check({nm, "_start_addr"}, {63'(ord_addr), obusy}, 64'd1);
    cyc = 1;
    while (!odone && cyc < 8000) begin
      if (spur && !injected && ord_addr == AW'(5*16+3)) begin
        istart = 1'b1; injected = 1'b1;
      end else istart = 1'b0;
      tick();
      cyc++;
    end
    istart = 1'b0;
    spur_armed = 1'b0;
    check({nm, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    tick();
    check({nm, "_idle_after"}, {62'd0, obusy, odone}, 64'd0);
    check({nm, "_writes"}, 64'(wr_cnt), 64'd1024);
    check({nm, "_dones"}, 64'(done_cnt), 64'd1);
    check({nm, "_starts"}, 64'(start_cnt), 64'(exp_starts));
    check({nm, "_addr_order"}, 64'(addr_err), 64'd0);
    check({nm, "_blk_stable"}, 64'(stab_err), 64'd0);
    check_image(nm);
  endtask

  typedef struct {
    int          mode;
    int          cw;
    int          pat;
    int          exp_cyc;
    logic [63:0] exp_first;
    bit          chk_first;
  } vec_t;

  initial begin
    vec_t tbl[4];
    int   w, guard;
    tbl[0] = '{0, 3, 0, 64*(17+1+3+16)+1, 64'h0123456789ABCDEF, 1'b1};
    tbl[1] = '{1, 3, 0, 64*(17+1+3+16)+1, 64'h0123456789ABCDEF, 1'b1};
    tbl[2] = '{2, 1, 1, 64*(17+1+1+16)+1, 64'hFEDCBA9876543210, 1'b1};
    tbl[3] = '{0, 6, 2, 64*(17+1+6+16)+1, 64'h0, 1'b0};

    irst = 1'b1; istart = 1'b0; clr = 1'b0; spur_armed = 1'b0;
    cmode = 0; cwait = 3; ckey = '0;
`ifdef RCB_BYPASS_EN
    ibypass = 1'b0;
`endif
    fill_rx(0);
    for (int n = 0; n < NW; n++) tx_ram[n] = '0;
    clear_env();
    tick();

    check("rst_addrs", {44'd0, ord_addr, owr_addr}, 64'd0);
    check("rst_ctrl", {58'd0, owdata, owrite_en, ocipher_start}, 64'd0);
    check("rst_status", {62'd0, obusy, odone}, 64'd0);
    check("rst_block", oblock, 64'd0);

    // reset wins over a simultaneous start
    istart = 1'b1;
    tick();
    check("rst_start_busy", {63'd0, obusy}, 64'd0);
    irst = 1'b0; istart = 1'b0;
    tick();
    check("rst_start_idle", {63'd0, obusy}, 64'd0);

    for (int t = 0; t < 4; t++) begin
      cmode = tbl[t].mode; cwait = tbl[t].cw; ckey = {$urandom, $urandom};
      fill_rx(tbl[t].pat);
      run_buffer($sformatf("vec%0d", t), tbl[t].exp_cyc, 1'b0, 64);
      if (tbl[t].chk_first) check($sformatf("vec%0d_first_blk", t), first_blk, tbl[t].exp_first);
    end

    for (int r = 0; r < 2; r++) begin
      w = $urandom_range(1, 5);
      cmode = $urandom_range(0, 2); cwait = w; ckey = {$urandom, $urandom};
      fill_rx(2);
      run_buffer($sformatf("rand%0d", r), 64*(17+1+w+16)+1, 1'b0, 64);
    end

    // stray istart in LOAD and stray done pulses in STORE are ignored
    cmode = 0; cwait = 3; fill_rx(0);
    run_buffer("spur", 64*(17+1+3+16)+1, 1'b1, 64);

    // reset while block 10 waits for the cipher
    cmode = 1; cwait = 5; fill_rx(2);
    clear_env();
    istart = 1'b1;
    tick();
    istart = 1'b0;
    guard = 0;
    while (start_cnt < 11 && guard < 3000) begin tick(); guard++; end
    check("abort_reached", 64'(start_cnt), 64'd11);
    irst = 1'b1;
    tick();
    check("abort_busy", {62'd0, obusy, owrite_en}, 64'd0);
    irst = 1'b0;
    check("abort_writes", 64'(wr_cnt), 64'd160);
    repeat (20) tick();
    check("abort_no_more_writes", 64'(wr_cnt), 64'd160);
    check("abort_idle", {63'd0, obusy}, 64'd0);
    run_buffer("restart", 64*(17+1+5+16)+1, 1'b0, 64);

`ifdef RCB_BYPASS_EN
    cmode = 0; cwait = 3; fill_rx(2);
    ibypass = 1'b1;
    run_buffer("bypass", 64*35+1, 1'b0, 0);
    ibypass = 1'b0;
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
